symbol_serializer: RTL

SYMBOL_SERIALIZER -- requirements
Module: symbol_serializer

---
 rtl/symbol_serializer.sv | 117 +++++++++++
 1 files changed

// File: rtl/symbol_serializer.sv
// rtl/symbol_serializer.sv - framed MSB-first serializer behind a small input FIFO
// Optional SYMBOL_SERIALIZER_IDLE_GAP_EN inserts one idle-high bit after every frame.
module symbol_serializer #(
    parameter int DATA_WIDTH = 10,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-2:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic                  out_bit,
    output logic                  busy,
    output logic                  frame_done
);
    localparam int PW = DATA_WIDTH - 1;
    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(DATA_WIDTH);
    localparam logic [CW-1:0] LAST_BIT = CW'(DATA_WIDTH - 1);
    localparam logic [CW-1:0] LAST_M1  = CW'(DATA_WIDTH - 2);
    localparam logic [AW:0]   DEPTH    = (AW+1)'(FIFO_DEPTH);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_SEND = 2'd1;
`ifdef SYMBOL_SERIALIZER_IDLE_GAP_EN
    localparam logic [1:0] S_GAP  = 2'd2;
`endif

    logic [PW-1:0] r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic [1:0]    r_state;
    logic [CW-1:0] r_bit_cnt;
    logic [PW-1:0] r_shift;
    logic          r_out_bit;
    logic          r_frame_done;

    logic w_push;
    logic w_pop;
    logic w_empty;

    assign in_ready   = (r_count < DEPTH);
    assign w_push     = in_valid && in_ready;
    assign w_empty    = (r_count == '0);
    assign out_bit    = r_out_bit;
    assign frame_done = r_frame_done;
    assign busy       = (r_state != S_IDLE);

    // A pop is the moment a new frame's start bit is committed to the line.
    always_comb begin
        w_pop = 1'b0;
        case (r_state)
            S_IDLE:  w_pop = !w_empty;
`ifdef SYMBOL_SERIALIZER_IDLE_GAP_EN
            S_GAP:   w_pop = !w_empty;
`else
            S_SEND:  w_pop = !w_empty && (r_bit_cnt == LAST_BIT);
`endif
            default: w_pop = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            if (w_push && !w_pop)
                r_count <= r_count + 1'b1;
            else if (!w_push && w_pop)
                r_count <= r_count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= in_data;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= S_IDLE;
            r_bit_cnt    <= '0;
            r_shift      <= '0;
            r_out_bit    <= 1'b1;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= 1'b0;
            if (w_pop) begin
                r_state   <= S_SEND;
                r_bit_cnt <= '0;
                r_shift   <= r_mem[r_rd_ptr];
                r_out_bit <= 1'b0;
            end else if (r_state == S_SEND) begin
                if (r_bit_cnt == LAST_BIT) begin
`ifdef SYMBOL_SERIALIZER_IDLE_GAP_EN
                    r_state   <= S_GAP;
`else
                    r_state   <= S_IDLE;
`endif
                    r_out_bit <= 1'b1;
                end else begin
                    r_out_bit    <= r_shift[PW-1];
                    r_shift      <= {r_shift[PW-2:0], 1'b0};
                    r_bit_cnt    <= r_bit_cnt + 1'b1;
                    r_frame_done <= (r_bit_cnt == LAST_M1);
                end
            end else begin
                r_state   <= S_IDLE;
                r_out_bit <= 1'b1;
            end
        end
    end
endmodule
